// File: rtl/fault_detection_writer.sv
// -----------------------------------------------------------------------------
// fault_detection_writer
//
// Collects the per-PE mismatch reports that the test-response comparator
// produces while scan patterns run on the systolic array. It accumulates them
// in a sticky N x N fail map and then classifies the failures:
//   - row faults    : rows whose failing-PE count reaches FAULT_THRESHOLD
//   - column faults : columns whose failing-PE count reaches FAULT_THRESHOLD
//   - single faults : failing PEs that are not covered by a row or column fault
// The result is written into the eNVM faulty-PE storage, one row address per
// cycle.
//
// Ports
//   clk                    : clock, all logic on the rising edge
//   rst_n                  : asynchronous active-low reset
//   test_start             : pulse, clear the fail map and start a session
//                            (aborts any session in progress)
//   test_done              : pulse, all patterns applied, classify + write back
//   mismatch_valid         : mismatch_row / mismatch_vec are valid this cycle
//   mismatch_row           : row of the reported mismatches
//   mismatch_vec           : bit c set = PE (mismatch_row, c) failed
//   detection_en           : eNVM write strobe
//   detection_addr         : row address being written
//   single_pe_detection    : isolated faulty PEs of detection_addr
//   row_fault_detection    : bit r set = row r faulty
//   column_fault_detection : bit c set = column c faulty
//   total_fault_count      : number of failing PEs in the map
//   busy                   : session in progress
//   done                   : one-cycle pulse, write-back complete
//
// All outputs are registered.
// -----------------------------------------------------------------------------
module fault_detection_writer #(
    parameter int SYSTOLIC_SIZE   = 8,
    parameter int ADDR_WIDTH      = $clog2(SYSTOLIC_SIZE),
    parameter int FAULT_THRESHOLD = SYSTOLIC_SIZE / 2,
    parameter int COUNT_WIDTH     = $clog2(SYSTOLIC_SIZE * SYSTOLIC_SIZE + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     test_start,
    input  logic                     test_done,
    input  logic                     mismatch_valid,
    input  logic [ADDR_WIDTH-1:0]    mismatch_row,
    input  logic [SYSTOLIC_SIZE-1:0] mismatch_vec,
    output logic                     detection_en,
    output logic [ADDR_WIDTH-1:0]    detection_addr,
    output logic [SYSTOLIC_SIZE-1:0] single_pe_detection,
    output logic [SYSTOLIC_SIZE-1:0] row_fault_detection,
    output logic [SYSTOLIC_SIZE-1:0] column_fault_detection,
    output logic [COUNT_WIDTH-1:0]   total_fault_count,
    output logic                     busy,
    output logic                     done
);

    // Width able to hold a count of 0..SYSTOLIC_SIZE failing PEs in one line.
    localparam int LINE_CW = $clog2(SYSTOLIC_SIZE + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COLLECT = 3'd1,
        EVAL    = 3'd2,
        WRITE   = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t state_reg;
    state_t state_next;

    // Sticky fail map: bit c of fail_map_reg[r] = PE (r, c) failed at least once.
    logic [SYSTOLIC_SIZE-1:0] fail_map_reg [SYSTOLIC_SIZE];

    // Registered outputs and their next values.
    logic                     detection_en_reg;
    logic                     detection_en_next;
    logic [ADDR_WIDTH-1:0]    detection_addr_reg;
    logic [ADDR_WIDTH-1:0]    detection_addr_next;
    logic [SYSTOLIC_SIZE-1:0] single_reg;
    logic [SYSTOLIC_SIZE-1:0] single_next;
    logic [SYSTOLIC_SIZE-1:0] row_det_reg;
    logic [SYSTOLIC_SIZE-1:0] row_det_next;
    logic [SYSTOLIC_SIZE-1:0] col_det_reg;
    logic [SYSTOLIC_SIZE-1:0] col_det_next;
    logic [COUNT_WIDTH-1:0]   total_reg;
    logic [COUNT_WIDTH-1:0]   total_next;
    logic                     busy_reg;
    logic                     busy_next;
    logic                     done_reg;
    logic                     done_next;

    // Classification of the current map contents.
    logic [SYSTOLIC_SIZE-1:0] row_fault_comb;
    logic [SYSTOLIC_SIZE-1:0] col_fault_comb;
    logic [COUNT_WIDTH-1:0]   total_comb;

    // Map control.
    logic                     clear_map;
    logic                     merge_en;

    // Row whose single-PE vector is loaded into the output register this edge.
    logic [ADDR_WIDTH-1:0]    sel_row;
    logic                     last_write;

    // -------------------------------------------------------------------------
    // Per-line popcounts and threshold compares
    // -------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < SYSTOLIC_SIZE; gi++) begin : g_line
            logic [LINE_CW-1:0] row_cnt;
            logic [LINE_CW-1:0] col_cnt;

            always_comb begin
                row_cnt = '0;
                col_cnt = '0;
                for (int j = 0; j < SYSTOLIC_SIZE; j++) begin
                    row_cnt = row_cnt + LINE_CW'(fail_map_reg[gi][j]);
                    col_cnt = col_cnt + LINE_CW'(fail_map_reg[j][gi]);
                end
            end

            assign row_fault_comb[gi] = (row_cnt >= LINE_CW'(FAULT_THRESHOLD));
            assign col_fault_comb[gi] = (col_cnt >= LINE_CW'(FAULT_THRESHOLD));
        end
    endgenerate

    // Whole-map popcount, full width so it never saturates.
    always_comb begin
        total_comb = '0;
        for (int r = 0; r < SYSTOLIC_SIZE; r++) begin
            for (int c = 0; c < SYSTOLIC_SIZE; c++) begin
                total_comb = total_comb + COUNT_WIDTH'(fail_map_reg[r][c]);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Fail map
    // -------------------------------------------------------------------------
    // test_start clears the map from any state. A mismatch reported in the same
    // cycle as test_start belongs to the aborted session and is dropped.
    assign clear_map = test_start;
    assign merge_en  = (state_reg == COLLECT) && mismatch_valid && !test_start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < SYSTOLIC_SIZE; r++) begin
                fail_map_reg[r] <= '0;
            end
        end else if (clear_map) begin
            for (int r = 0; r < SYSTOLIC_SIZE; r++) begin
                fail_map_reg[r] <= '0;
            end
        end else if (merge_en) begin
            for (int r = 0; r < SYSTOLIC_SIZE; r++) begin
                if (mismatch_row == ADDR_WIDTH'(r)) begin
                    fail_map_reg[r] <= fail_map_reg[r] | mismatch_vec;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // FSM: state register and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg          <= IDLE;
            detection_en_reg   <= 1'b0;
            detection_addr_reg <= '0;
            single_reg         <= '0;
            row_det_reg        <= '0;
            col_det_reg        <= '0;
            total_reg          <= '0;
            busy_reg           <= 1'b0;
            done_reg           <= 1'b0;
        end else begin
            state_reg          <= state_next;
            detection_en_reg   <= detection_en_next;
            detection_addr_reg <= detection_addr_next;
            single_reg         <= single_next;
            row_det_reg        <= row_det_next;
            col_det_reg        <= col_det_next;
            total_reg          <= total_next;
            busy_reg           <= busy_next;
            done_reg           <= done_next;
        end
    end

    // The output register always shows the row currently being written, so the
    // counter for the WRITE phase is detection_addr_reg itself.
    assign last_write = (detection_addr_reg == ADDR_WIDTH'(SYSTOLIC_SIZE - 1));

    // In EVAL the first write (row 0) is loaded; in WRITE the following row.
    // The map is frozen from EVAL onward, so the combinational classification
    // equals the values captured in EVAL and can be used for every row.
    assign sel_row = (state_reg == EVAL) ? '0 : ADDR_WIDTH'(detection_addr_reg + ADDR_WIDTH'(1));

    // -------------------------------------------------------------------------
    // FSM: next state and next outputs
    // -------------------------------------------------------------------------
    always_comb begin
        state_next          = state_reg;
        detection_en_next   = 1'b0;
        detection_addr_next = '0;
        single_next         = '0;
        row_det_next        = row_det_reg;
        col_det_next        = col_det_reg;
        total_next          = total_reg;
        done_next           = 1'b0;

        case (state_reg)
            IDLE: begin
                if (test_start) begin
                    state_next = COLLECT;
                end
            end

            COLLECT: begin
                if (test_start) begin
                    state_next = COLLECT;
                end else if (test_done) begin
                    state_next = EVAL;
                end
            end

            EVAL: begin
                if (test_start) begin
                    state_next = COLLECT;
                end else begin
                    state_next          = WRITE;
                    row_det_next        = row_fault_comb;
                    col_det_next        = col_fault_comb;
                    total_next          = total_comb;
                    detection_en_next   = 1'b1;
                    detection_addr_next = sel_row;
                    single_next         = fail_map_reg[sel_row] & ~col_fault_comb
                                          & {SYSTOLIC_SIZE{~row_fault_comb[sel_row]}};
                end
            end

            WRITE: begin
                if (test_start) begin
                    // Abort: the strobe drops on the next cycle; rows already
                    // written stay in the eNVM.
                    state_next = COLLECT;
                end else if (last_write) begin
                    state_next = DONE;
                    done_next  = 1'b1;
                end else begin
                    detection_en_next   = 1'b1;
                    detection_addr_next = sel_row;
                    single_next         = fail_map_reg[sel_row] & ~col_fault_comb
                                          & {SYSTOLIC_SIZE{~row_fault_comb[sel_row]}};
                end
            end

            DONE: begin
                if (test_start) begin
                    state_next = COLLECT;
                end else begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        busy_next = (state_next != IDLE);
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign detection_en           = detection_en_reg;
    assign detection_addr         = detection_addr_reg;
    assign single_pe_detection    = single_reg;
    assign row_fault_detection    = row_det_reg;
    assign column_fault_detection = col_det_reg;
    assign total_fault_count      = total_reg;
    assign busy                   = busy_reg;
    assign done                   = done_reg;

endmodule

// File: tb/tb_fault_detection_writer.sv
// -----------------------------------------------------------------------------
// tb_fault_detection_writer
//
// Self-checking bench for fault_detection_writer. Stimulus tasks keep a
// behavioural fail map; when test_done is issued the expected eNVM writes are
// computed from that map and pushed into a queue. A monitor pops one entry per
// detection_en cycle and compares it. Timing, reset and abort behaviour are
// checked directly by the stimulus process.
// -----------------------------------------------------------------------------
module tb_fault_detection_writer;

    localparam int N  = 8;
    localparam int AW = 3;
    localparam int CW = 7;
    localparam int TH = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          test_start = 1'b0;
    logic          test_done = 1'b0;
    logic          mismatch_valid = 1'b0;
    logic [AW-1:0] mismatch_row = '0;
    logic [N-1:0]  mismatch_vec = '0;
    logic          detection_en;
    logic [AW-1:0] detection_addr;
    logic [N-1:0]  single_pe_detection;
    logic [N-1:0]  row_fault_detection;
    logic [N-1:0]  column_fault_detection;
    logic [CW-1:0] total_fault_count;
    logic          busy;
    logic          done;

    fault_detection_writer dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .test_start             (test_start),
        .test_done              (test_done),
        .mismatch_valid         (mismatch_valid),
        .mismatch_row           (mismatch_row),
        .mismatch_vec           (mismatch_vec),
        .detection_en           (detection_en),
        .detection_addr         (detection_addr),
        .single_pe_detection    (single_pe_detection),
        .row_fault_detection    (row_fault_detection),
        .column_fault_detection (column_fault_detection),
        .total_fault_count      (total_fault_count),
        .busy                   (busy),
        .done                   (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference fail map: model_map[r][c] = PE (r, c) has failed this session.
    bit model_map [N][N];

    typedef struct {
        logic [AW-1:0] addr;
        logic [N-1:0]  single;
        logic [N-1:0]  row;
        logic [N-1:0]  col;
        logic [CW-1:0] total;
    } exp_t;

    exp_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic void clear_model();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                model_map[r][c] = 1'b0;
    endfunction

    // Classify the reference map and queue the N expected eNVM writes.
    function automatic void push_expected();
        int rc[N];
        int cc[N];
        int tot;
        logic [N-1:0] rowf;
        logic [N-1:0] colf;
        exp_t e;
        tot = 0;
        for (int i = 0; i < N; i++) begin
            rc[i] = 0;
            cc[i] = 0;
        end
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                if (model_map[r][c]) begin
                    rc[r]++;
                    cc[c]++;
                    tot++;
                end
        for (int i = 0; i < N; i++) begin
            rowf[i] = (rc[i] >= TH);
            colf[i] = (cc[i] >= TH);
        end
        for (int k = 0; k < N; k++) begin
            e.addr = AW'(k);
            for (int c = 0; c < N; c++)
                e.single[c] = model_map[k][c] && !colf[c] && !rowf[k];
            e.row   = rowf;
            e.col   = colf;
            e.total = tot[CW-1:0];
            exp_q.push_back(e);
        end
    endfunction

    // Monitor: one expected entry per write strobe.
    always @(negedge clk) begin
        if (rst_n && detection_en) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write actual addr=%0d required no write", detection_addr);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                $display("write addr=%0d single=%02h row=%02h col=%02h total=%0d",
                         detection_addr, single_pe_detection, row_fault_detection,
                         column_fault_detection, total_fault_count);
                check("write_addr",   detection_addr,         e.addr);
                check("write_single", single_pe_detection,    e.single);
                check("write_row",    row_fault_detection,    e.row);
                check("write_col",    column_fault_detection, e.col);
                check("write_total",  total_fault_count,      e.total);
            end
        end
    end

    task automatic start_session();
        test_start = 1'b1;
        @(posedge clk); #1;
        test_start = 1'b0;
        clear_model();
        check("start_busy", busy, 1);
    endtask

    task automatic send(input int r, input logic [N-1:0] v);
        mismatch_valid = 1'b1;
        mismatch_row   = AW'(r);
        mismatch_vec   = v;
        @(posedge clk); #1;
        mismatch_valid = 1'b0;
        for (int c = 0; c < N; c++)
            if (v[c]) model_map[r][c] = 1'b1;
    endtask

    // Mismatch reported while no session is collecting: must be ignored.
    task automatic send_ignored(input int r, input logic [N-1:0] v);
        mismatch_valid = 1'b1;
        mismatch_row   = AW'(r);
        mismatch_vec   = v;
        @(posedge clk); #1;
        mismatch_valid = 1'b0;
    endtask

    task automatic finish_session(input bit with_mm, input int r, input logic [N-1:0] v);
        test_done = 1'b1;
        if (with_mm) begin
            mismatch_valid = 1'b1;
            mismatch_row   = AW'(r);
            mismatch_vec   = v;
            for (int c = 0; c < N; c++)
                if (v[c]) model_map[r][c] = 1'b1;
        end
        push_expected();
        @(posedge clk); #1;
        test_done      = 1'b0;
        mismatch_valid = 1'b0;
        check("eval_no_write", detection_en, 0);
        check("eval_busy", busy, 1);
        repeat (N + 1) @(posedge clk);
        #1;
        check("done_pulse", done, 1);
        check("done_busy", busy, 1);
        check("writes_consumed", exp_q.size(), 0);
        @(posedge clk); #1;
        check("done_cleared", done, 0);
        check("busy_cleared", busy, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_det_en"}, detection_en, 0);
        check({tag, "_addr"},   detection_addr, 0);
        check({tag, "_single"}, single_pe_detection, 0);
        check({tag, "_row"},    row_fault_detection, 0);
        check({tag, "_col"},    column_fault_detection, 0);
        check({tag, "_total"},  total_fault_count, 0);
        check({tag, "_busy"},   busy, 0);
        check({tag, "_done"},   done, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_model();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // IDLE ignores test_done and mismatches
        send_ignored(2, 8'hFF);
        test_done = 1'b1;
        @(posedge clk); #1;
        test_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("idle_ignore_busy", busy, 0);
        check("idle_ignore_en", detection_en, 0);

        // No mismatches
        start_session();
        finish_session(1'b0, 0, '0);
        check("clean_total", total_fault_count, 0);

        // Single isolated mismatch
        start_session();
        send(3, 8'h10);
        finish_session(1'b0, 0, '0);
        check("single_total", total_fault_count, 1);
        check("single_row", row_fault_detection, 8'h00);
        check("single_col", column_fault_detection, 8'h00);

        // Row at threshold
        start_session();
        send(5, 8'hF0);
        finish_session(1'b0, 0, '0);
        check("rowf_row", row_fault_detection, 8'h20);
        check("rowf_total", total_fault_count, 4);

        // Column at threshold plus isolated PE
        start_session();
        for (int r = 0; r < 4; r++) send(r, 8'h04);
        send(7, 8'h01);
        finish_session(1'b0, 0, '0);
        check("colf_col", column_fault_detection, 8'h04);
        check("colf_row", row_fault_detection, 8'h00);
        check("colf_total", total_fault_count, 5);

        // Mismatch on the test_done edge
        start_session();
        finish_session(1'b1, 1, 8'h01);
        check("same_edge_total", total_fault_count, 1);

        // Repeated identical reports are sticky, not counted twice
        start_session();
        repeat (3) send(1, 8'h01);
        finish_session(1'b0, 0, '0);
        check("repeat_total", total_fault_count, 1);

        // Abort during WRITE at k=3
        start_session();
        send(0, 8'hFF);
        send(3, 8'h0F);
        test_done = 1'b1;
        push_expected();
        @(posedge clk); #1;
        test_done = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("abort_addr", detection_addr, 3);
        test_start = 1'b1;
        @(posedge clk); #1;
        test_start = 1'b0;
        check("abort_en_low", detection_en, 0);
        check("abort_busy", busy, 1);
        check("abort_done", done, 0);
        check("abort_remaining", exp_q.size(), 4);
        exp_q.delete();
        clear_model();
        finish_session(1'b0, 0, '0);
        check("abort_cleared_total", total_fault_count, 0);

        // Asynchronous reset mid-WRITE
        start_session();
        send(2, 8'h3C);
        send(6, 8'h81);
        test_done = 1'b1;
        push_expected();
        @(posedge clk); #1;
        test_done = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        exp_q.delete();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_busy", busy, 0);
        test_done = 1'b1;
        @(posedge clk); #1;
        test_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_idle_en", detection_en, 0);
        check("post_rst_idle_busy", busy, 0);

        // Randomized sessions
        for (int s = 0; s < 25; s++) begin
            if ($urandom_range(0, 2) == 0)
                send_ignored(int'($urandom_range(0, N - 1)), N'($urandom));
            start_session();
            for (int m = 0; m < int'($urandom_range(0, 10)); m++) begin
                int kind;
                int rr;
                kind = int'($urandom_range(0, 9));
                rr   = int'($urandom_range(0, N - 1));
                if (kind < 6) begin
                    send(rr, N'($urandom & $urandom & $urandom));
                end else if (kind < 8) begin
                    send(rr, N'($urandom | $urandom));
                end else if (kind == 8) begin
                    logic [N-1:0] cv;
                    cv = '0;
                    cv[$urandom_range(0, N - 1)] = 1'b1;
                    for (int r = 0; r < int'($urandom_range(2, 6)); r++)
                        send(int'($urandom_range(0, N - 1)), cv);
                end else begin
                    @(posedge clk); #1;
                end
            end
            finish_session(1'($urandom), int'($urandom_range(0, N - 1)),
                           N'($urandom & $urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
